// File: rtl/vending_controller.sv
// vending_controller
//   Vending-machine core FSM. Consumes the command stream (escolher / inserir_dinheiro /
//   dar_troco), tracks the selected product and credit, releases the product, returns
//   change as a greedy coin breakdown and accumulates the machine wallet (carteira).
//   All values are in cents.
//
// Optional feature macro: MOEDAS_CHECK_EN
//   When defined, an insertion is accepted only if the declared coin counts add up to
//   dinheiro_inserido; otherwise it is rejected with erro_cod=3.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   escolher            select command (acted on rising edge), produto_escolhido = code 1..4
//   inserir_dinheiro    insert command (acted on rising edge), dinheiro_inserido = cents,
//                       moedas_inseridas = {n100, n50, n25} coin counts
//   dar_troco           finish/change command (acted on rising edge)
//   estado              0 OCIOSO, 1 ESCOLHIDO, 2 PAGO, 3 TROCO
//   liberar             1-cycle pulse, produto_liberado held until next pulse
//   troco_valido        1-cycle pulse, troco/troco_moedas held until next pulse
//   carteira            wallet total, saturates at 4095
//   erro                1-cycle pulse, erro_cod (1 invalid, 2 aborted, 3 coin mismatch) held
module vending_controller #(
    parameter logic [7:0] PRECO_1 = 8'd50,
    parameter logic [7:0] PRECO_2 = 8'd75,
    parameter logic [7:0] PRECO_3 = 8'd100,
    parameter logic [7:0] PRECO_4 = 8'd125
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        escolher,
    input  logic [7:0]  produto_escolhido,
    input  logic        inserir_dinheiro,
    input  logic [7:0]  dinheiro_inserido,
    input  logic [11:0] moedas_inseridas,
    input  logic        dar_troco,
    output logic [1:0]  estado,
    output logic        liberar,
    output logic [7:0]  produto_liberado,
    output logic        troco_valido,
    output logic [7:0]  troco,
    output logic [11:0] troco_moedas,
    output logic [11:0] carteira,
    output logic        erro,
    output logic [1:0]  erro_cod
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ESCOLHIDO = 2'd1,
        PAGO      = 2'd2,
        TROCO     = 2'd3
    } estado_t;

    estado_t     estado_q, estado_d;
    logic        escolher_prev_q, inserir_prev_q, troco_prev_q;
    logic        rise_esc, rise_ins, rise_troco;
    logic [7:0]  codigo_q, codigo_d, preco_q, preco_d, credito_q, credito_d;
    logic        liberar_q, liberar_d, troco_valido_q, troco_valido_d, erro_q, erro_d;
    logic [7:0]  produto_liberado_q, produto_liberado_d, troco_q, troco_d;
    logic [11:0] troco_moedas_q, troco_moedas_d, carteira_q, carteira_d;
    logic [1:0]  erro_cod_q, erro_cod_d;

    logic [7:0]  preco_sel;
    logic        codigo_valido;
    logic [8:0]  soma_credito;
    logic [7:0]  credito_sat;
    logic        moedas_ok;
    logic [7:0]  troco_val, venda;
    logic [7:0]  n100_w, n50_w, n25_w, resto100, resto50, residuo;
    logic [11:0] moedas_calc;
    logic [8:0]  carteira_add;
    logic [12:0] soma_carteira;

    assign rise_esc   = escolher & ~escolher_prev_q;
    assign rise_ins   = inserir_dinheiro & ~inserir_prev_q;
    assign rise_troco = dar_troco & ~troco_prev_q;

    always_comb begin
        preco_sel     = '0;
        codigo_valido = 1'b1;
        case (produto_escolhido)
            8'd1:    preco_sel = PRECO_1;
            8'd2:    preco_sel = PRECO_2;
            8'd3:    preco_sel = PRECO_3;
            8'd4:    preco_sel = PRECO_4;
            default: codigo_valido = 1'b0;
        endcase
    end

    assign soma_credito = {1'b0, credito_q} + {1'b0, dinheiro_inserido};
    assign credito_sat  = soma_credito[8] ? 8'hFF : soma_credito[7:0];

`ifdef MOEDAS_CHECK_EN
    logic [11:0] soma_moedas;
    always_comb begin
        soma_moedas = 12'd25  * {8'd0, moedas_inseridas[3:0]}
                    + 12'd50  * {8'd0, moedas_inseridas[7:4]}
                    + 12'd100 * {8'd0, moedas_inseridas[11:8]};
        moedas_ok   = (soma_moedas == {4'd0, dinheiro_inserido});
    end
`else
    logic unused_moedas;
    always_comb begin
        moedas_ok     = 1'b1;
        unused_moedas = ^moedas_inseridas;
    end
`endif

    always_comb begin
        estado_d           = estado_q;
        codigo_d           = codigo_q;
        preco_d            = preco_q;
        credito_d          = credito_q;
        liberar_d          = 1'b0;
        produto_liberado_d = produto_liberado_q;
        troco_valido_d     = 1'b0;
        troco_d            = troco_q;
        troco_moedas_d     = troco_moedas_q;
        erro_d             = 1'b0;
        erro_cod_d         = erro_cod_q;
        troco_val          = '0;
        venda              = '0;

        // Priority dar_troco > inserir > escolher holds in every state: a higher rise
        // swallows lower ones even when the higher command itself is ignored.
        unique case (estado_q)
            OCIOSO: begin
                if (rise_esc && !rise_ins && !rise_troco) begin
                    if (codigo_valido) begin
                        codigo_d  = produto_escolhido;
                        preco_d   = preco_sel;
                        credito_d = '0;
                        estado_d  = ESCOLHIDO;
                    end else begin
                        erro_d     = 1'b1;
                        erro_cod_d = 2'd1;
                    end
                end
            end
            ESCOLHIDO, PAGO: begin
                if (rise_troco) begin
                    troco_valido_d = 1'b1;
                    credito_d      = '0;
                    if (estado_q == PAGO) begin
                        liberar_d          = 1'b1;
                        produto_liberado_d = codigo_q;
                        troco_val          = credito_q - preco_q;
                        venda              = preco_q;
                        estado_d           = TROCO;
                    end else begin
                        troco_val  = credito_q;
                        erro_d     = 1'b1;
                        erro_cod_d = 2'd2;
                        estado_d   = OCIOSO;
                    end
                end else if (rise_ins) begin
                    if (moedas_ok) begin
                        credito_d = credito_sat;
                        if (credito_sat >= preco_q) estado_d = PAGO;
                    end else begin
                        erro_d     = 1'b1;
                        erro_cod_d = 2'd3;
                    end
                end
            end
            TROCO: estado_d = OCIOSO;
        endcase

        // Greedy change; the sub-25 residue cannot be paid out so the machine keeps it.
        n100_w      = troco_val / 8'd100;
        resto100    = troco_val % 8'd100;
        n50_w       = resto100 / 8'd50;
        resto50     = resto100 % 8'd50;
        n25_w       = resto50 / 8'd25;
        residuo     = resto50 % 8'd25;
        moedas_calc = (12'(n100_w) << 8) | (12'(n50_w) << 4) | 12'(n25_w);

        if (troco_valido_d) begin
            troco_d        = troco_val;
            troco_moedas_d = moedas_calc;
        end

        carteira_add  = {1'b0, venda} + (troco_valido_d ? {1'b0, residuo} : 9'd0);
        soma_carteira = {1'b0, carteira_q} + {4'd0, carteira_add};
        carteira_d    = soma_carteira[12] ? 12'hFFF : soma_carteira[11:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q           <= OCIOSO;
            escolher_prev_q    <= 1'b0;
            inserir_prev_q     <= 1'b0;
            troco_prev_q       <= 1'b0;
            codigo_q           <= '0;
            preco_q            <= '0;
            credito_q          <= '0;
            liberar_q          <= 1'b0;
            produto_liberado_q <= '0;
            troco_valido_q     <= 1'b0;
            troco_q            <= '0;
            troco_moedas_q     <= '0;
            carteira_q         <= '0;
            erro_q             <= 1'b0;
            erro_cod_q         <= '0;
        end else begin
            estado_q           <= estado_d;
            escolher_prev_q    <= escolher;
            inserir_prev_q     <= inserir_dinheiro;
            troco_prev_q       <= dar_troco;
            codigo_q           <= codigo_d;
            preco_q            <= preco_d;
            credito_q          <= credito_d;
            liberar_q          <= liberar_d;
            produto_liberado_q <= produto_liberado_d;
            troco_valido_q     <= troco_valido_d;
            troco_q            <= troco_d;
            troco_moedas_q     <= troco_moedas_d;
            carteira_q         <= carteira_d;
            erro_q             <= erro_d;
            erro_cod_q         <= erro_cod_d;
        end
    end

    assign estado           = estado_q;
    assign liberar          = liberar_q;
    assign produto_liberado = produto_liberado_q;
    assign troco_valido     = troco_valido_q;
    assign troco            = troco_q;
    assign troco_moedas     = troco_moedas_q;
    assign carteira         = carteira_q;
    assign erro             = erro_q;
    assign erro_cod         = erro_cod_q;

endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller
//   Self-checking bench for vending_controller: directed purchase scenarios followed by
//   randomized command streams, all compared against a purchase-level reference model.
//   Honours MOEDAS_CHECK_EN the same way the design does.
`timescale 1ns/1ps
module tb_vending_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        escolher = 1'b0;
    logic [7:0]  produto_escolhido = '0;
    logic        inserir_dinheiro = 1'b0;
    logic [7:0]  dinheiro_inserido = '0;
    logic [11:0] moedas_inseridas = '0;
    logic        dar_troco = 1'b0;
    logic [1:0]  estado;
    logic        liberar;
    logic [7:0]  produto_liberado;
    logic        troco_valido;
    logic [7:0]  troco;
    logic [11:0] troco_moedas;
    logic [11:0] carteira;
    logic        erro;
    logic [1:0]  erro_cod;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clock = ~clock;

    vending_controller #(
        .PRECO_1(8'd50),
        .PRECO_2(8'd75),
        .PRECO_3(8'd100),
        .PRECO_4(8'd125)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .escolher         (escolher),
        .produto_escolhido(produto_escolhido),
        .inserir_dinheiro (inserir_dinheiro),
        .dinheiro_inserido(dinheiro_inserido),
        .moedas_inseridas (moedas_inseridas),
        .dar_troco        (dar_troco),
        .estado           (estado),
        .liberar          (liberar),
        .produto_liberado (produto_liberado),
        .troco_valido     (troco_valido),
        .troco            (troco),
        .troco_moedas     (troco_moedas),
        .carteira         (carteira),
        .erro             (erro),
        .erro_cod         (erro_cod)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a purchase session (phase, product, price, credit, wallet) plus
    // the most recently announced release / change / error.
    int m_phase, m_code, m_price, m_credit, m_wallet;
    bit p_esc, p_ins, p_dt;
    int e_lib, e_prod, e_tv, e_troco, e_moedas, e_err, e_cod;

    function automatic int price_of(input int code);
        case (code)
            1: return 50;
            2: return 75;
            3: return 100;
            default: return 125;
        endcase
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic int coins_for(input int amount);
        int n100, n50, n25;
        n100 = amount / 100;
        n50  = (amount % 100) / 50;
        n25  = (amount % 50) / 25;
        return n100 * 256 + n50 * 16 + n25;
    endfunction

    function automatic bit coins_ok(input int din, input int moedas);
`ifdef MOEDAS_CHECK_EN
        return (25 * (moedas & 15) + 50 * ((moedas >> 4) & 15) + 100 * ((moedas >> 8) & 15)) == din;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_phase = 0; m_code = 0; m_price = 0; m_credit = 0; m_wallet = 0;
        p_esc = 0; p_ins = 0; p_dt = 0;
        e_lib = 0; e_prod = 0; e_tv = 0; e_troco = 0; e_moedas = 0; e_err = 0; e_cod = 0;
    endtask

    task automatic give_change(input int amount);
        e_tv     = 1;
        e_troco  = amount;
        e_moedas = coins_for(amount);
        m_wallet = sat(m_wallet + amount % 25, 4095);
    endtask

    task automatic insert_money();
        if (coins_ok(int'(dinheiro_inserido), int'(moedas_inseridas))) begin
            m_credit = sat(m_credit + int'(dinheiro_inserido), 255);
            if (m_credit >= m_price) m_phase = 2;
        end else begin
            e_err = 1; e_cod = 3;
        end
    endtask

    task automatic model_step();
        bit r_esc, r_ins, r_dt;
        r_esc = escolher && !p_esc;
        r_ins = inserir_dinheiro && !p_ins;
        r_dt  = dar_troco && !p_dt;
        p_esc = escolher; p_ins = inserir_dinheiro; p_dt = dar_troco;
        e_lib = 0; e_tv = 0; e_err = 0;
        if (r_dt) begin
            r_ins = 0; r_esc = 0;
        end else if (r_ins) begin
            r_esc = 0;
        end
        case (m_phase)
            0: if (r_esc) begin
                if (produto_escolhido >= 1 && produto_escolhido <= 4) begin
                    m_code = int'(produto_escolhido); m_price = price_of(m_code);
                    m_credit = 0; m_phase = 1;
                end else begin
                    e_err = 1; e_cod = 1;
                end
            end
            1: if (r_dt) begin
                give_change(m_credit);
                e_err = 1; e_cod = 2; m_credit = 0; m_phase = 0;
            end else if (r_ins) insert_money();
            2: if (r_dt) begin
                e_lib = 1; e_prod = m_code;
                m_wallet = sat(m_wallet + m_price, 4095);
                give_change(m_credit - m_price);
                m_credit = 0; m_phase = 3;
            end else if (r_ins) insert_money();
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        check("estado", 32'(estado), 32'(m_phase));
        check("liberar", 32'(liberar), 32'(e_lib));
        check("produto_liberado", 32'(produto_liberado), 32'(e_prod));
        check("troco_valido", 32'(troco_valido), 32'(e_tv));
        check("troco", 32'(troco), 32'(e_troco));
        check("troco_moedas", 32'(troco_moedas), 32'(e_moedas));
        check("carteira", 32'(carteira), 32'(m_wallet));
        check("erro", 32'(erro), 32'(e_err));
        check("erro_cod", 32'(erro_cod), 32'(e_cod));
    endtask

    // Called at posedge+1; inputs are changed between steps, never at an edge.
    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit esc, input int prod, input bit ins, input int din,
                         input int moedas, input bit dt);
        escolher          = esc;
        produto_escolhido = 8'(prod);
        inserir_dinheiro  = ins;
        dinheiro_inserido = 8'(din);
        moedas_inseridas  = 12'(moedas);
        dar_troco         = dt;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        int din, moedas;
        model_reset();
        #1 reset = 1'b1;
        #2;
        compare_all();
        check("reset_estado", 32'(estado), 32'd0);
        check("reset_carteira", 32'(carteira), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // 1: product 1, pay 150 with one R$0,50 and one R$1,00
        drive(1, 1, 0, 0, 0, 0);
        check("t1_estado_escolhido", 32'(estado), 32'd1);
        drive(0, 1, 1, 150, 12'h110, 0);
        check("t1_estado_pago", 32'(estado), 32'd2);
        drive(0, 0, 0, 0, 0, 1);
        check("t1_liberar", 32'(liberar), 32'd1);
        check("t1_produto", 32'(produto_liberado), 32'd1);
        check("t1_troco", 32'(troco), 32'd100);
        check("t1_moedas", 32'(troco_moedas), 32'h100);
        check("t1_carteira", 32'(carteira), 32'd50);
        idle(2);
        check("t1_back_idle", 32'(estado), 32'd0);

        // 2: product 2, pay 100 with 2 x 0,25 + 1 x 0,50
        drive(1, 2, 0, 0, 0, 0);
        drive(0, 2, 1, 100, 12'h012, 0);
        drive(0, 0, 0, 0, 0, 1);
        check("t2_troco", 32'(troco), 32'd25);
        check("t2_moedas", 32'(troco_moedas), 32'h001);
        check("t2_carteira", 32'(carteira), 32'd125);
        idle(2);

        // 3: product 3, only 50 inserted, then abort
        drive(1, 3, 0, 0, 0, 0);
        drive(0, 3, 1, 50, 12'h010, 0);
        check("t3_still_escolhido", 32'(estado), 32'd1);
        drive(0, 0, 0, 0, 0, 1);
        check("t3_erro", 32'(erro), 32'd1);
        check("t3_erro_cod", 32'(erro_cod), 32'd2);
        check("t3_troco", 32'(troco), 32'd50);
        check("t3_moedas", 32'(troco_moedas), 32'h010);
        check("t3_no_liberar", 32'(liberar), 32'd0);
        check("t3_carteira", 32'(carteira), 32'd125);
        idle(1);

        // 4: invalid codes; held command acts once
        drive(1, 0, 0, 0, 0, 0);
        check("t4_code0_cod", 32'(erro_cod), 32'd1);
        check("t4_code0_estado", 32'(estado), 32'd0);
        idle(1);
        drive(1, 5, 0, 0, 0, 0);
        check("t4_code5_erro", 32'(erro), 32'd1);
        check("t4_code5_cod", 32'(erro_cod), 32'd1);
        idle(1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            cnt += int'(erro);
        end
        check("t4_held_once", 32'(cnt), 32'd1);
        idle(1);

        // 5: escolher and dar_troco rise together in OCIOSO
        drive(1, 1, 0, 0, 0, 1);
        check("t5_estado", 32'(estado), 32'd0);
        check("t5_no_erro", 32'(erro), 32'd0);
        idle(1);

`ifdef MOEDAS_CHECK_EN
        // 6: declared coins do not add up
        drive(1, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 150, 12'h100, 0);
        check("t6_erro_cod", 32'(erro_cod), 32'd3);
        check("t6_estado", 32'(estado), 32'd1);
        idle(1);
        drive(0, 0, 0, 0, 0, 1);
        idle(1);
`endif

        // Reset while in PAGO wipes credit, outputs and wallet
        drive(1, 4, 0, 0, 0, 0);
        drive(0, 4, 1, 200, 12'h200, 0);
        check("rst_pre_pago", 32'(estado), 32'd2);
        apply_reset();
        check("rst_estado", 32'(estado), 32'd0);
        check("rst_carteira", 32'(carteira), 32'd0);
        check("rst_troco", 32'(troco), 32'd0);
        idle(1);

        // Randomized command streams
        for (int i = 0; i < 4000; i++) begin
            if (i % 700 == 699) apply_reset();
            din = ($urandom_range(0, 1) == 1) ? 25 * $urandom_range(0, 10) : $urandom_range(0, 255);
            moedas = (din % 25 == 0 && $urandom_range(0, 3) != 0) ? coins_for(din)
                                                                   : $urandom_range(0, 4095);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 5),
                  $urandom_range(0, 2) == 0, din, moedas,
                  $urandom_range(0, 5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
